debug_run_controller: RTL and testbench

//  Run/halt/step sequencer for the single-cycle RISC-V core. Drives the core's clock-enable so software
//  can run freely, halt, or advance N instructions, and walks the core's debug register-select port to

---
 rtl/dbg_pkg.sv | 17 +
 rtl/dbg_reg_dump_seq.sv | 62 ++++++
 rtl/debug_run_controller.sv | 173 +++++++++++++++++
 tb/tb_debug_run_controller.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_pkg.sv
// Shared constants for the debug run controller: default widths and the FSM state encoding.
package dbg_pkg;

    localparam int DBG_XLEN       = 32;
    localparam int DBG_SEL_W      = 5;
    localparam int DBG_NUM_REGS   = 32;
    localparam int DBG_STEP_CNT_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t ST_HALTED       = 3'd0;
    localparam state_t ST_RUNNING      = 3'd1;
    localparam state_t ST_STEPPING     = 3'd2;
    localparam state_t ST_DUMP_LOAD    = 3'd3;
    localparam state_t ST_DUMP_PRESENT = 3'd4;

endpackage

// File: rtl/dbg_reg_dump_seq.sv
// Register-dump walker: steps the debug select through every register and
// presents each value as one valid/ready beat.
module dbg_reg_dump_seq
    import dbg_pkg::*;
#(
    parameter int XLEN     = DBG_XLEN,
    parameter int SEL_W    = DBG_SEL_W,
    parameter int NUM_REGS = DBG_NUM_REGS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             load,
    input  logic             present,
    input  logic             abort,
    input  logic             dump_ready,
    input  logic [XLEN-1:0]  dbg_data_in,
    output logic [SEL_W-1:0] dbg_sel,
    output logic [XLEN-1:0]  dump_data,
    output logic [SEL_W-1:0] dump_idx,
    output logic             dump_valid,
    output logic             dump_last,
    output logic             accept,
    output logic             finish
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

    logic [SEL_W-1:0] idx_q;

    assign dbg_sel = idx_q;
    // A halt in the same cycle as ready wins: the beat is not consumed.
    assign accept  = present && dump_valid && dump_ready && !abort;
    assign finish  = accept && dump_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q      <= '0;
            dump_data  <= '0;
            dump_idx   <= '0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
        end else begin
            if (start) begin
                idx_q <= '0;
            end else if (accept && !dump_last) begin
                idx_q <= idx_q + SEL_W'(1);
            end

            if (load && !abort) begin
                dump_data  <= dbg_data_in;
                dump_idx   <= idx_q;
                dump_valid <= 1'b1;
                dump_last  <= (idx_q == LAST_IDX);
            end else if (accept || abort) begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/debug_run_controller.sv
// Run/halt/step/dump sequencer driving the core clock-enable and debug register port.
// Optional breakpoint comparator enabled by defining DEBUG_BREAKPOINT_EN.
//
// state         | meaning
// HALTED        | core frozen, accepting step/dump/run requests
// RUNNING       | core enabled every cycle until halt (or breakpoint)
// STEPPING      | core enabled for the remaining step count, then HALTED
// DUMP_LOAD     | dbg_sel driven, register value captured into the beat
// DUMP_PRESENT  | beat valid, waiting for dump_ready
module debug_run_controller
    import dbg_pkg::*;
#(
    parameter int XLEN       = DBG_XLEN,
    parameter int NUM_REGS   = DBG_NUM_REGS,
    parameter int SEL_W      = DBG_SEL_W,
    parameter int STEP_CNT_W = DBG_STEP_CNT_W,
    parameter int RESET_RUN  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_req,
    input  logic                  halt_req,
    input  logic                  step_req,
    input  logic [STEP_CNT_W-1:0] step_count,
    input  logic                  dump_req,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [XLEN-1:0]       dbg_data_in,
    input  logic [XLEN-1:0]       bp_addr,
    input  logic                  bp_valid,
    output logic                  cpu_en,
    output logic [SEL_W-1:0]      dbg_sel,
    output logic [XLEN-1:0]       dump_data,
    output logic [SEL_W-1:0]      dump_idx,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic                  dump_last,
    output logic [2:0]            state,
    output logic [XLEN-1:0]       instr_count,
    output logic                  bp_hit
);

    localparam state_t RESET_STATE = (RESET_RUN != 0) ? ST_RUNNING : ST_HALTED;

    state_t                state_q, state_d;
    logic [STEP_CNT_W-1:0] remaining_q, remaining_d;
    logic [XLEN-1:0]       count_q;
    logic                  in_exec;
    logic                  bp_match;
    logic                  dump_start;
    logic                  dump_accept;
    logic                  dump_finish;

    assign state       = state_q;
    assign instr_count = count_q;
    assign in_exec     = (state_q == ST_RUNNING) || (state_q == ST_STEPPING);
    assign cpu_en      = in_exec && !bp_match;

`ifdef DEBUG_BREAKPOINT_EN
    logic resume_q;
    logic bp_hit_q;
    logic resuming;

    // The first cycle after leaving HALTED lets the core step off a breakpoint it stopped on.
    assign bp_match = in_exec && !resume_q && bp_valid && (pc_in == bp_addr);
    assign resuming = (state_q == ST_HALTED) &&
                      ((state_d == ST_RUNNING) || (state_d == ST_STEPPING));
    assign bp_hit   = bp_hit_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resume_q <= (RESET_RUN != 0);
            bp_hit_q <= 1'b0;
        end else begin
            resume_q <= resuming;
            if (bp_match) begin
                bp_hit_q <= 1'b1;
            end else if (resuming) begin
                bp_hit_q <= 1'b0;
            end
        end
    end
`else
    logic unused_bp;

    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
    assign unused_bp = ^{bp_addr, bp_valid, pc_in};
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        dump_start  = 1'b0;
        case (state_q)
            ST_HALTED: begin
                if (!halt_req) begin
                    if (step_req) begin
                        state_d     = ST_STEPPING;
                        remaining_d = (step_count == '0) ? STEP_CNT_W'(1) : step_count;
                    end else if (dump_req) begin
                        state_d    = ST_DUMP_LOAD;
                        dump_start = 1'b1;
                    end else if (run_req) begin
                        state_d = ST_RUNNING;
                    end
                end
            end
            ST_RUNNING: begin
                if (halt_req || bp_match) begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEPPING: begin
                if (halt_req || bp_match) begin
                    state_d = ST_HALTED;
                end else begin
                    remaining_d = remaining_q - STEP_CNT_W'(1);
                    if (remaining_q <= STEP_CNT_W'(1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            ST_DUMP_LOAD: begin
                state_d = halt_req ? ST_HALTED : ST_DUMP_PRESENT;
            end
            ST_DUMP_PRESENT: begin
                if (halt_req || dump_finish) begin
                    state_d = ST_HALTED;
                end else if (dump_accept) begin
                    state_d = ST_DUMP_LOAD;
                end
            end
            default: state_d = ST_HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            remaining_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            if (cpu_en) begin
                count_q <= count_q + XLEN'(1);
            end
        end
    end

    dbg_reg_dump_seq #(
        .XLEN     (XLEN),
        .SEL_W    (SEL_W),
        .NUM_REGS (NUM_REGS)
    ) u_dump_seq (
        .clk         (clk),
        .reset       (reset),
        .start       (dump_start),
        .load        (state_q == ST_DUMP_LOAD),
        .present     (state_q == ST_DUMP_PRESENT),
        .abort       (halt_req),
        .dump_ready  (dump_ready),
        .dbg_data_in (dbg_data_in),
        .dbg_sel     (dbg_sel),
        .dump_data   (dump_data),
        .dump_idx    (dump_idx),
        .dump_valid  (dump_valid),
        .dump_last   (dump_last),
        .accept      (dump_accept),
        .finish      (dump_finish)
    );

endmodule

// File: tb/tb_debug_run_controller.sv
// Self-checking bench for debug_run_controller: enable counting, dump scoreboard, abort and priority cases.
module tb_debug_run_controller;

    localparam int XLEN = 32;
    localparam int SEL_W = 5;
    localparam int STEP_CNT_W = 8;
    localparam int NUM_REGS = 32;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  run_req, halt_req, step_req, dump_req;
    logic [STEP_CNT_W-1:0] step_count;
    logic [XLEN-1:0]       pc_in, dbg_data_in, bp_addr;
    logic                  bp_valid;
    logic                  cpu_en;
    logic [SEL_W-1:0]      dbg_sel;
    logic [XLEN-1:0]       dump_data;
    logic [SEL_W-1:0]      dump_idx;
    logic                  dump_valid, dump_ready, dump_last;
    logic [2:0]            state;
    logic [XLEN-1:0]       instr_count;
    logic                  bp_hit;

    debug_run_controller #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .STEP_CNT_W(STEP_CNT_W), .RESET_RUN(0)
    ) dut (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req), .step_req(step_req),
        .step_count(step_count), .dump_req(dump_req), .pc_in(pc_in), .dbg_data_in(dbg_data_in),
        .bp_addr(bp_addr), .bp_valid(bp_valid), .cpu_en(cpu_en), .dbg_sel(dbg_sel),
        .dump_data(dump_data), .dump_idx(dump_idx), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_last(dump_last), .state(state), .instr_count(instr_count), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    // Core model: register file reads back idx*4, PC advances by 4 per retired instruction.
    assign dbg_data_in = 32'(dbg_sel) * 32'd4;
    always @(posedge clk or posedge reset) begin
        if (reset) pc_in <= '0;
        else if (cpu_en) pc_in <= pc_in + 32'd4;
    end

    typedef struct {
        logic [SEL_W-1:0] idx;
        logic [XLEN-1:0]  data;
        logic             last;
    } beat_t;

    beat_t sb_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int beats = 0;
    int last_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic             hold_pending = 1'b0;
    logic [SEL_W-1:0] prev_idx;
    logic [XLEN-1:0]  prev_data;

    always @(negedge clk) begin
        beat_t e;
        if (!reset) begin
            if (cpu_en) en_cnt++;
            if (hold_pending && dump_valid) begin
                check("hold_idx", dump_idx, prev_idx);
                check("hold_data", dump_data, prev_data);
            end
            hold_pending = dump_valid && !dump_ready;
            prev_idx = dump_idx;
            prev_data = dump_data;
            if (dump_valid && dump_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_beat", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("beat_idx", dump_idx, e.idx);
                    check("beat_data", dump_data, e.data);
                    check("beat_last", dump_last, e.last);
                    beats++;
                    if (dump_last) last_cnt++;
                end
            end
        end
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_dump();
        beat_t b;
        for (int i = 0; i < NUM_REGS; i++) begin
            b.idx = SEL_W'(i);
            b.data = 32'(i * 4);
            b.last = (i == NUM_REGS - 1);
            sb_q.push_back(b);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) wait_cycle();
        reset = 1'b0;
        wait_cycle();
    endtask

    task automatic wait_halted(input string tag, input int bound);
        int i;
        i = 0;
        while (state != 3'd0 && i < bound) begin
            wait_cycle();
            i++;
        end
        check(tag, state, 3'd0);
    endtask

    task automatic wait_beat_idx(input string tag, input int idx);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            wait_cycle();
            if (dump_valid && dump_idx == SEL_W'(idx)) found = 1'b1;
        end
        check(tag, found, 1);
    endtask

    int en_base, beat_base, last_base;

    initial begin
        reset = 1'b1;
        {run_req, halt_req, step_req, dump_req, bp_valid, dump_ready} = '0;
        step_count = '0;
        bp_addr = 32'h10;
        do_reset();

        check("rst_state", state, 3'd0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_instr_count", instr_count, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dbg_sel", dbg_sel, 0);
        check("rst_bp_hit", bp_hit, 0);

        // step 3
        en_base = en_cnt;
        step_req = 1'b1; step_count = 8'd3;
        wait_cycle();
        step_req = 1'b0;
        repeat (8) wait_cycle();
        check("step3_enables", en_cnt - en_base, 3);
        check("step3_instr_count", instr_count, 3);
        check("step3_state", state, 3'd0);

        // run, halt seen during the 10th running cycle
        en_base = en_cnt;
        run_req = 1'b1;
        wait_cycle();
        run_req = 1'b0;
        check("run_state", state, 3'd1);
        repeat (9) wait_cycle();
        halt_req = 1'b1;
        wait_cycle();
        halt_req = 1'b0;
        check("run_cpu_en_after_halt", cpu_en, 0);
        check("run_state_after_halt", state, 3'd0);
        repeat (3) wait_cycle();
        check("run_enables", en_cnt - en_base, 10);
        check("run_instr_count", instr_count, 13);

        // full dump with ready held high
        beat_base = beats; last_base = last_cnt;
        dump_ready = 1'b1;
        push_dump();
        dump_req = 1'b1;
        wait_cycle();
        dump_req = 1'b0;
        check("dump_state_load", state, 3'd3);
        wait_halted("dump_done", 200);
        wait_cycle();
        check("dump_beats", beats - beat_base, 32);
        check("dump_last_count", last_cnt - last_base, 1);
        check("dump_sb_empty", sb_q.size(), 0);
        check("dump_no_enable", instr_count, 13);

        // back-pressure on beat 7, then halt on beat 12
        beat_base = beats; last_base = last_cnt;
        push_dump();
        dump_req = 1'b1;
        wait_cycle();
        dump_req = 1'b0;
        wait_beat_idx("bp_beat7_seen", 7);
        dump_ready = 1'b0;
        repeat (5) wait_cycle();
        check("bp_beat7_still_valid", dump_valid, 1);
        dump_ready = 1'b1;
        wait_beat_idx("abort_beat12_seen", 12);
        dump_ready = 1'b0;
        halt_req = 1'b1;
        wait_cycle();
        halt_req = 1'b0;
        check("abort_valid_dropped", dump_valid, 0);
        check("abort_no_last", dump_last, 0);
        check("abort_state", state, 3'd0);
        wait_cycle();
        check("abort_beats", beats - beat_base, 12);
        check("abort_last_count", last_cnt - last_base, 0);
        check("abort_sb_left", sb_q.size(), 20);
        sb_q.delete();
        dump_ready = 1'b1;

        // halt beats step in the same cycle
        en_base = en_cnt;
        halt_req = 1'b1; step_req = 1'b1; step_count = 8'd4;
        wait_cycle();
        {halt_req, step_req} = '0;
        repeat (6) wait_cycle();
        check("halt_step_enables", en_cnt - en_base, 0);
        check("halt_step_state", state, 3'd0);

        // step_count 0 behaves as 1
        en_base = en_cnt;
        step_req = 1'b1; step_count = 8'd0;
        wait_cycle();
        step_req = 1'b0;
        repeat (5) wait_cycle();
        check("step0_enables", en_cnt - en_base, 1);
        check("step0_instr_count", instr_count, 14);

        // step beats dump and run
        en_base = en_cnt; beat_base = beats;
        step_req = 1'b1; dump_req = 1'b1; run_req = 1'b1; step_count = 8'd2;
        wait_cycle();
        {step_req, dump_req, run_req} = '0;
        repeat (6) wait_cycle();
        check("prio_enables", en_cnt - en_base, 2);
        check("prio_no_beats", beats - beat_base, 0);
        check("prio_state", state, 3'd0);
        check("prio_instr_count", instr_count, 16);

        // reset while running
        run_req = 1'b1;
        wait_cycle();
        run_req = 1'b0;
        repeat (3) wait_cycle();
        check("midrun_state", state, 3'd1);
        do_reset();
        check("midrun_rst_state", state, 3'd0);
        check("midrun_rst_cpu_en", cpu_en, 0);
        check("midrun_rst_instr_count", instr_count, 0);

`ifdef DEBUG_BREAKPOINT_EN
        bp_valid = 1'b1;
        en_base = en_cnt;
        run_req = 1'b1;
        wait_cycle();
        run_req = 1'b0;
        repeat (10) wait_cycle();
        check("bp_run_enables", en_cnt - en_base, 4);
        check("bp_state", state, 3'd0);
        check("bp_hit_set", bp_hit, 1);
        check("bp_pc", pc_in, 32'h10);
        en_base = en_cnt;
        step_req = 1'b1; step_count = 8'd1;
        wait_cycle();
        step_req = 1'b0;
        repeat (4) wait_cycle();
        check("bp_step_enables", en_cnt - en_base, 1);
        check("bp_step_pc", pc_in, 32'h14);
        check("bp_hit_cleared", bp_hit, 0);
        bp_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
